// File: rtl/multicore_pkg.sv
// rtl/multicore_pkg.sv - shared instruction widths, address split constants and cache state encoding
package multicore_pkg;

  localparam int INST_SIZE = 32;
  // OFFSET: byte-within-instruction address bits; WORD_BITS: instruction-within-line bits of the default line
  localparam int OFFSET    = 2;
  localparam int WORD_BITS = 2;

  typedef enum logic [2:0] {
    FLUSH       = 3'd0,
    IDLE        = 3'd1,
    LOOKUP      = 3'd2,
    REFILL_REQ  = 3'd3,
    REFILL_DATA = 3'd4,
    RESPOND     = 3'd5
  } icache_state_t;

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/plru_tree.sv
// rtl/plru_tree.sv - per-set tree pseudo-LRU state with touch and victim selection
// Node bits point toward the least recently used half; a single way needs no state.
module plru_tree #(
  parameter int WAYS = 4,
  parameter int SETS = 64,
  localparam int IDX_BITS = (SETS > 1) ? $clog2(SETS) : 1,
  localparam int WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int NODES    = (WAYS > 1) ? WAYS - 1 : 1
) (
  input  logic                i_aclk,
  input  logic                i_areset,
  input  logic                i_clr,
  input  logic [IDX_BITS-1:0] i_clr_idx,
  input  logic                i_upd,
  input  logic [IDX_BITS-1:0] i_upd_idx,
  input  logic [WAY_BITS-1:0] i_upd_way,
  input  logic [IDX_BITS-1:0] i_rd_idx,
  output logic [WAY_BITS-1:0] o_victim
);

  function automatic logic [NODES-1:0] touch(input logic [NODES-1:0] t, input logic [WAY_BITS-1:0] way);
    logic [NODES-1:0] r;
    int node;
    r    = t;
    node = 1;
    for (int l = WAY_BITS - 1; l >= 0; l--) begin
      r[node-1] = ~way[l];
      node      = 2 * node + int'(way[l]);
    end
    return r;
  endfunction

  function automatic logic [WAY_BITS-1:0] pick(input logic [NODES-1:0] t);
    int node;
    node = 1;
    for (int l = 0; l < WAY_BITS; l++) begin
      node = 2 * node + int'(t[node-1]);
    end
    return WAY_BITS'(node - WAYS);
  endfunction

  if (WAYS == 1) begin : g_direct
    logic unused_plru;
    assign unused_plru = ^{i_aclk, i_areset, i_clr, i_clr_idx, i_upd, i_upd_idx, i_upd_way, i_rd_idx};
    assign o_victim    = '0;
  end else begin : g_tree
    logic [NODES-1:0] bits [SETS];

    always_ff @(posedge i_aclk or posedge i_areset) begin
      if (i_areset) begin
        for (int s = 0; s < SETS; s++) bits[s] <= '0;
      end else if (i_clr) begin
        bits[i_clr_idx] <= '0;
      end else if (i_upd) begin
        bits[i_upd_idx] <= touch(bits[i_upd_idx], i_upd_way);
      end
    end

    assign o_victim = pick(bits[i_rd_idx]);
  end

endmodule

// File: rtl/instr_cache_nway.sv
// rtl/instr_cache_nway.sv - n-way set-associative instruction cache with line refill and fence.i flush
// Define ICACHE_PERF_CNT_EN to add saturating hit/miss counters on o_hit_cnt/o_miss_cnt.
module instr_cache_nway
  import multicore_pkg::*;
#(
  parameter int ADDR_SIZE      = 32,
  parameter int CACHE_SIZE     = 2**14,
  parameter int BLK_PER_SET    = 4,
  parameter int WORDS_PER_LINE = 1 << WORD_BITS
) (
  input  logic                 i_aclk,
  input  logic                 i_areset,
  input  logic                 i_req,
  input  logic [ADDR_SIZE-1:0] i_addr,
  output logic                 o_ready,
  input  logic                 i_flush,
  output logic                 o_instr_valid,
  output logic [INST_SIZE-1:0] o_instruction,
  output logic                 o_mem_req,
  output logic [ADDR_SIZE-1:0] o_mem_addr,
  input  logic                 i_mem_ready,
  input  logic                 i_mem_rvalid,
  input  logic [INST_SIZE-1:0] i_mem_rdata
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]          o_hit_cnt,
  output logic [31:0]          o_miss_cnt
`endif
);

  localparam int WL_BITS    = $clog2(WORDS_PER_LINE);
  localparam int LINE_LSB   = OFFSET + WL_BITS;
  localparam int LINE_W     = WORDS_PER_LINE * INST_SIZE;
  localparam int DEPTH      = CACHE_SIZE / BLK_PER_SET / (WORDS_PER_LINE * INST_SIZE / 8);
  localparam int INDEX_BITS = $clog2(DEPTH);
  localparam int TAG_BITS   = ADDR_SIZE - LINE_LSB - INDEX_BITS;
  localparam int WAY_BITS   = clog2_min1(BLK_PER_SET);

  icache_state_t          state;
  logic [ADDR_SIZE-1:0]   req_addr;
  logic [INDEX_BITS-1:0]  flush_cnt;
  logic [WL_BITS-1:0]     beat_cnt;
  logic [LINE_W-1:0]      line_buf;
  logic [WAY_BITS-1:0]    victim_way;
  logic                   flush_pending;

  logic [TAG_BITS-1:0]    tag_mem  [BLK_PER_SET][DEPTH];
  logic [LINE_W-1:0]      data_mem [BLK_PER_SET][DEPTH];
  logic [DEPTH-1:0]       valid_mem [BLK_PER_SET];
  logic [TAG_BITS-1:0]    rd_tag   [BLK_PER_SET];
  logic [LINE_W-1:0]      rd_line  [BLK_PER_SET];
  logic [BLK_PER_SET-1:0] rd_valid;

  logic [INDEX_BITS-1:0]  in_idx, req_idx;
  logic [TAG_BITS-1:0]    req_tag;
  logic [WL_BITS-1:0]     req_word;
  logic [BLK_PER_SET-1:0] hit_vec;
  logic [WAY_BITS-1:0]    hit_way, miss_victim, plru_victim, plru_upd_way;
  logic [INST_SIZE-1:0]   hit_word, resp_word;
  logic [LINE_W-1:0]      refill_line;
  logic                   lookup_hit, lookup_miss, accept, refill_we, victim_found;
  logic                   unused_req_bits;

  assign in_idx   = i_addr[LINE_LSB +: INDEX_BITS];
  assign req_idx  = req_addr[LINE_LSB +: INDEX_BITS];
  assign req_tag  = req_addr[ADDR_SIZE-1 -: TAG_BITS];
  assign req_word = req_addr[OFFSET +: WL_BITS];
  assign unused_req_bits = ^req_addr[OFFSET-1:0];

  always_comb begin
    hit_vec  = '0;
    hit_way  = '0;
    hit_word = '0;
    for (int w = 0; w < BLK_PER_SET; w++) begin
      if (rd_valid[w] && rd_tag[w] == req_tag) begin
        hit_vec[w] = 1'b1;
        hit_way    = WAY_BITS'(w);
        hit_word   = rd_line[w][req_word*INST_SIZE +: INST_SIZE];
      end
    end
  end

  // Fill empty ways before disturbing any resident line.
  always_comb begin
    miss_victim  = plru_victim;
    victim_found = 1'b0;
    for (int w = 0; w < BLK_PER_SET; w++) begin
      if (!rd_valid[w] && !victim_found) begin
        miss_victim  = WAY_BITS'(w);
        victim_found = 1'b1;
      end
    end
  end

  always_comb begin
    refill_line = line_buf;
    refill_line[beat_cnt*INST_SIZE +: INST_SIZE] = i_mem_rdata;
  end

  assign resp_word     = line_buf[req_word*INST_SIZE +: INST_SIZE];
  assign lookup_hit    = (state == LOOKUP) && (|hit_vec);
  assign lookup_miss   = (state == LOOKUP) && !(|hit_vec);
  assign o_ready       = ((state == IDLE) || lookup_hit) && !flush_pending && !i_flush;
  assign accept        = i_req && o_ready;
  assign refill_we     = (state == REFILL_DATA) && i_mem_rvalid && (beat_cnt == WL_BITS'(WORDS_PER_LINE - 1));
  assign o_instr_valid = lookup_hit || (state == RESPOND);
  assign o_instruction = lookup_hit ? hit_word : ((state == RESPOND) ? resp_word : '0);
  assign plru_upd_way  = (state == RESPOND) ? victim_way : hit_way;

  plru_tree #(
    .WAYS (BLK_PER_SET),
    .SETS (DEPTH)
  ) u_plru (
    .i_aclk    (i_aclk),
    .i_areset  (i_areset),
    .i_clr     (state == FLUSH),
    .i_clr_idx (flush_cnt),
    .i_upd     (lookup_hit || (state == RESPOND)),
    .i_upd_idx (req_idx),
    .i_upd_way (plru_upd_way),
    .i_rd_idx  (req_idx),
    .o_victim  (plru_victim)
  );

  // Arrays carry no reset; the FLUSH pass that follows reset invalidates every set.
  always_ff @(posedge i_aclk) begin
    for (int w = 0; w < BLK_PER_SET; w++) begin
      if (state == FLUSH) begin
        valid_mem[w][flush_cnt] <= 1'b0;
      end else if (refill_we && victim_way == WAY_BITS'(w)) begin
        valid_mem[w][req_idx] <= 1'b1;
        tag_mem[w][req_idx]   <= req_tag;
        data_mem[w][req_idx]  <= refill_line;
      end
      if (accept) begin
        rd_tag[w]   <= tag_mem[w][in_idx];
        rd_line[w]  <= data_mem[w][in_idx];
        rd_valid[w] <= valid_mem[w][in_idx];
      end
    end
  end

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      state         <= FLUSH;
      req_addr      <= '0;
      flush_cnt     <= '0;
      beat_cnt      <= '0;
      line_buf      <= '0;
      victim_way    <= '0;
      flush_pending <= 1'b0;
      o_mem_req     <= 1'b0;
      o_mem_addr    <= '0;
    end else begin
      if (i_flush) flush_pending <= 1'b1;
      case (state)
        FLUSH: begin
          flush_cnt <= flush_cnt + 1'b1;
          if (flush_cnt == INDEX_BITS'(DEPTH - 1)) state <= IDLE;
        end
        IDLE: begin
          if (flush_pending || i_flush) begin
            state         <= FLUSH;
            flush_pending <= 1'b0;
          end else if (accept) begin
            state    <= LOOKUP;
            req_addr <= i_addr;
          end
        end
        LOOKUP: begin
          if (|hit_vec) begin
            if (accept) req_addr <= i_addr;
            else        state    <= IDLE;
          end else begin
            victim_way <= miss_victim;
            o_mem_req  <= 1'b1;
            o_mem_addr <= {req_addr[ADDR_SIZE-1:LINE_LSB], {LINE_LSB{1'b0}}};
            state      <= REFILL_REQ;
          end
        end
        REFILL_REQ: begin
          if (i_mem_ready) begin
            o_mem_req <= 1'b0;
            beat_cnt  <= '0;
            state     <= REFILL_DATA;
          end
        end
        REFILL_DATA: begin
          if (i_mem_rvalid) begin
            line_buf <= refill_line;
            beat_cnt <= beat_cnt + 1'b1;
            if (refill_we) state <= RESPOND;
          end
        end
        RESPOND: begin
          if (flush_pending || i_flush) begin
            state         <= FLUSH;
            flush_pending <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= FLUSH;
      endcase
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      o_hit_cnt  <= '0;
      o_miss_cnt <= '0;
    end else begin
      if (lookup_hit && o_hit_cnt != '1)   o_hit_cnt  <= o_hit_cnt + 1'b1;
      if (lookup_miss && o_miss_cnt != '1) o_miss_cnt <= o_miss_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_cache_nway.sv
// tb/tb_instr_cache_nway.sv - directed scoreboard bench for instr_cache_nway (1 KiB, 2-way, 4-word lines)
module tb_instr_cache_nway;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [31:0] addr = '0;
  logic        main_flush = 1'b0;
  logic        resp_flush = 1'b0;
  logic        flush;
  logic        ready, instr_valid, mem_req;
  logic [31:0] instruction, mem_addr;
  logic        mem_ready = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  int          n_vec = 0;
  int          n_err = 0;
  int          n_refill = 0;
  int          flush_beat = -1;
  int          n;
  logic [31:0] last_refill_addr = '0;
  logic [31:0] la;
  logic [31:0] sb[$];

  assign flush = main_flush | resp_flush;

  always #5 clk = ~clk;

  instr_cache_nway #(
    .ADDR_SIZE      (32),
    .CACHE_SIZE     (1024),
    .BLK_PER_SET    (2),
    .WORDS_PER_LINE (4)
  ) dut (
    .i_aclk        (clk),
    .i_areset      (rst),
    .i_req         (req),
    .i_addr        (addr),
    .o_ready       (ready),
    .i_flush       (flush),
    .o_instr_valid (instr_valid),
    .o_instruction (instruction),
    .o_mem_req     (mem_req),
    .o_mem_addr    (mem_addr),
    .i_mem_ready   (mem_ready),
    .i_mem_rvalid  (mem_rvalid),
    .i_mem_rdata   (mem_rdata)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .o_hit_cnt     (hit_cnt),
    .o_miss_cnt    (miss_cnt)
`endif
  );

  function automatic logic [31:0] model(input logic [31:0] a);
    if ((a & 32'hFFFF_FFF0) == 32'h100) return 32'hA0 + 32'(a[3:2]);
    return {a[31:2], 2'b00} ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic count_ready_low(output int cnt);
    cnt = 0;
    while (cnt < 200) begin
      @(negedge clk);
      if (ready) break;
      cnt++;
    end
  endtask

  // Called at the negedge where o_ready is high with the request driven.
  task automatic complete(input logic [31:0] a, input int exp_miss);
    int lat;
    int r0;
    sb.push_back(model(a));
    r0 = n_refill;
    @(posedge clk); #1;
    req = 1'b0;
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (instr_valid) break;
    end
    check("valid_seen", instr_valid, 1'b1);
    check("refill_count", n_refill - r0, exp_miss);
    if (exp_miss != 0) check("refill_addr", last_refill_addr, a & 32'hFFFF_FFF0);
    else               check("hit_latency", lat, 1);
  endtask

  task automatic fetch(input logic [31:0] a, input int exp_miss);
    int g;
    @(posedge clk); #1;
    req  = 1'b1;
    addr = a;
    g = 0;
    while (g < 200) begin
      @(negedge clk);
      g++;
      if (ready) break;
    end
    check("accept", ready, 1'b1);
    complete(a, exp_miss);
  endtask

  task automatic burst4(input logic [31:0] base);
    int nvalid;
    int k;
    int guard;
    nvalid = 0; k = 0; guard = 0;
    @(posedge clk); #1;
    req  = 1'b1;
    addr = base;
    while (k < 4 && guard < 50) begin
      @(negedge clk);
      guard++;
      if (instr_valid) nvalid++;
      if (ready) begin
        sb.push_back(model(addr));
        k++;
        @(posedge clk); #1;
        if (k < 4) addr = base + 32'(4 * k);
        else       req = 1'b0;
      end
    end
    @(negedge clk);
    if (instr_valid) nvalid++;
    check("burst_valids", nvalid, 4);
    check("burst_cycles", guard, 4);
  endtask

  always @(negedge clk) begin
    if (!rst && instr_valid) begin
      check("sb_extra", sb.size() == 0, 1'b0);
      if (sb.size() != 0) check("sb_data", instruction, sb.pop_front());
    end
  end

  // Refill responder: a stray beat before the handshake, then four beats with a stall before beat 2.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && mem_req) begin
        la = mem_addr;
        n_refill++;
        last_refill_addr = mem_addr;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        mem_ready  = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
          if (k == 2) begin
            mem_rvalid = 1'b0;
            @(posedge clk); #1;
          end
          mem_rvalid = 1'b1;
          mem_rdata  = model(la + 32'(4 * k));
          resp_flush = (flush_beat == k);
          @(posedge clk); #1;
          resp_flush = 1'b0;
        end
        mem_rvalid = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ready", ready, 1'b0);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_instr", instruction, 32'h0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    count_ready_low(n);
    check("reset_flush_len", n, 32);

    fetch(32'h100, 1);
    fetch(32'h10C, 0);
`ifdef ICACHE_PERF_CNT_EN
    check("hit_cnt", hit_cnt, 1);
    check("miss_cnt", miss_cnt, 1);
`endif
    burst4(32'h100);

    fetch(32'h500, 1);
    fetch(32'h100, 0);
    fetch(32'h900, 1);
    fetch(32'h100, 0);
    fetch(32'h500, 1);
    fetch(32'h100, 0);

    flush_beat = 2;
    fetch(32'hD00, 1);
    flush_beat = -1;
    count_ready_low(n);
    check("flush_after_refill_len", n, 32);
    fetch(32'h100, 1);

    @(posedge clk); #1;
    req        = 1'b1;
    addr       = 32'h104;
    main_flush = 1'b1;
    @(negedge clk);
    check("flush_prio_ready", ready, 1'b0);
    @(posedge clk); #1;
    main_flush = 1'b0;
    count_ready_low(n);
    check("flush_prio_len", n, 32);
    complete(32'h104, 1);

    repeat (3) @(negedge clk);
    check("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_cache_nway.md
INSTR_CACHE_NWAY -- requirements
Module: instr_cache_nway

Interface
REQ-001 SHALL have parameter ADDR_SIZE, 32, fetch address width.
REQ-002 SHALL have parameter CACHE_SIZE, 2**14, total bytes; power of two.
REQ-003 SHALL have parameter BLK_PER_SET, 4, ways; power of two, 1..8.
REQ-004 SHALL have parameter WORDS_PER_LINE, 4, instructions per line; power of two, >=2.
REQ-005 SHALL have port i_aclk  in  1  single clock; all logic on rising edge.
REQ-006 SHALL have port i_areset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port i_req  in  1  fetch request.
REQ-008 SHALL have port i_addr  in  ADDR_SIZE  fetch byte address; bits [1:0] ignored.
REQ-009 SHALL have port o_ready  out  1  request accepted when i_req && o_ready.
REQ-010 SHALL have port i_flush  in  1  invalidate whole cache (fence.i).
REQ-011 SHALL have port o_instr_valid  out  1  o_instruction valid, one-cycle pulse per request.
REQ-012 SHALL have port o_instruction  out  INST_SIZE  returned instruction.
REQ-013 SHALL have port o_mem_req  out  1  refill request, held until i_mem_ready.
REQ-014 SHALL have port o_mem_addr  out  ADDR_SIZE  line-aligned refill address.
REQ-015 SHALL have port i_mem_ready  in  1  refill request accepted.
REQ-016 SHALL have port i_mem_rvalid  in  1  refill beat valid.
REQ-017 SHALL have port i_mem_rdata  in  INST_SIZE  refill beat, ascending word order.

Function
REQ-018 SHALL use index = addr[OFFSET+WORD_BITS +: INDEX_BITS], tag = remaining MSBs, INDEX_BITS = log2(CACHE_SIZE/BLK_PER_SET/line bytes).
REQ-019 SHALL implement states FLUSH, IDLE, LOOKUP, REFILL_REQ, REFILL_DATA, RESPOND.
REQ-020 SHALL assert o_ready = (IDLE, or LOOKUP with hit) && !flush_pending && !i_flush.
REQ-021 SHALL on accept register address, issue synchronous array read, enter LOOKUP.
REQ-022 SHALL on LOOKUP hit drive o_instr_valid=1 with the addressed word that cycle (latency 1), update PLRU toward the hit way; back-to-back hits sustain one per cycle.
REQ-023 SHALL on LOOKUP miss select victim = lowest-numbered invalid way, else PLRU victim, and enter REFILL_REQ.
REQ-024 SHALL hold o_mem_req/o_mem_addr stable in REFILL_REQ until i_mem_ready, then enter REFILL_DATA.
REQ-025 SHALL count WORDS_PER_LINE rvalid beats (stalls allowed); after the last beat write tag, valid=1, line to victim way and enter RESPOND.
REQ-026 SHALL in RESPOND drive o_instr_valid=1 with requested word from the line buffer, update PLRU, return to IDLE.
REQ-027 SHALL latch i_flush asserted in any state into flush_pending; honour it only from IDLE or after RESPOND, never aborting a refill.
REQ-028 SHALL in FLUSH clear valid bits of all ways at one index per cycle, 0..CACHE_DEPTH-1, clear PLRU, then enter IDLE.
REQ-029 SHALL give flush priority over a same-cycle request; request not accepted.
REQ-030 SHALL ignore i_mem_rvalid outside REFILL_DATA.
REQ-031 SHALL with BLK_PER_SET=1 degenerate to direct-mapped, no PLRU state.

Reset
REQ-032 SHALL on i_areset force o_ready=0, o_instr_valid=0, o_instruction=0, o_mem_req=0, o_mem_addr=0, counters 0, flush_pending=0.
REQ-033 SHALL leave reset in FLUSH, o_ready=1 first after CACHE_DEPTH cycles.
REQ-034 SHALL on reset mid-refill discard the partial line; no array write.

Configuration
REQ-035 SHALL with ICACHE_PERF_CNT_EN defined add outputs o_hit_cnt, o_miss_cnt (32 bits, saturating, +1 per LOOKUP hit/miss); without it ports and logic absent, behaviour otherwise identical.

Structure
REQ-036 SHALL take INST_SIZE, WORD_BITS, OFFSET and the state enum icache_state_t from multicore_pkg.
REQ-037 SHALL place tree-PLRU (BLK_PER_SET-1 bits/set, update and victim logic) in sub-module plru_tree.

Verification
Config CACHE_SIZE=1024, BLK_PER_SET=2, WORDS_PER_LINE=4: 32 sets, tag 23 bits.
REQ-038 Reset release -> o_ready low exactly 32 cycles, then high.
REQ-039 Cold read 0x100 -> o_mem_addr=0x100, 4 beats 0xA0..0xA3 -> o_instr_valid with 0xA0; read 0x10C -> hit 1 cycle later, 0xA3, no o_mem_req.
REQ-040 Fill 0x100, 0x500, touch 0x100, read 0x900 (same set) -> refill evicts 0x500 way; re-read 0x100 hits.
REQ-041 i_flush during REFILL_DATA beat 2 -> refill completes, response delivered, then 32 flush cycles; read 0x100 misses.
REQ-042 i_req and i_flush same IDLE cycle -> o_ready=0, flush runs, request accepted after.
REQ-043 ICACHE_PERF_CNT_EN, sequence of REQ-039 -> o_hit_cnt=1, o_miss_cnt=1.
